// File: rtl/gap_builder.sv
// gap_builder: bit-serial word generator, the encode-side partner of the gap
// scanner. It builds a WORD_WIDTH-bit word LSB first. The word starts with a 1.
// Each gap g taken over the valid/ready handshake adds g zeros and then another 1.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset, clears all state
//   start      begin a new word (sampled only in IDLE or DONE)
//   gap_in     gap length (zeros between consecutive ones)
//   gap_valid  gap_in / gap_last valid
//   gap_last   this gap is the final one of the word
//   gap_ready  builder accepts a gap this cycle (high only while waiting for one)
//   Data       assembled word, meaningful when done=1
//   done       word complete, or aborted by overflow
//   overflow   requested pattern did not fit in WORD_WIDTH bits
module gap_builder #(
  parameter int WORD_WIDTH = 16,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GAP_WIDTH-1:0]  gap_in,
  input  logic                  gap_valid,
  input  logic                  gap_last,
  output logic                  gap_ready,
  output logic [WORD_WIDTH-1:0] Data,
  output logic                  done,
  output logic                  overflow
);

  localparam int POS_W = $clog2(WORD_WIDTH) + 1;
  localparam logic [POS_W-1:0]      POS_FULL = POS_W'(WORD_WIDTH);
  localparam logic [WORD_WIDTH-1:0] BIT0     = WORD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_WAIT_GAP,
    S_ZEROS,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [POS_W-1:0]      r_pos;
  logic [GAP_WIDTH-1:0]  r_cnt;
  logic                  r_last;
  logic [WORD_WIDTH-1:0] r_data;
  logic                  r_done;
  logic                  r_ovf;

  assign gap_ready = (r_state == S_WAIT_GAP);
  assign Data      = r_data;
  assign done      = r_done;
  assign overflow  = r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_data  <= '0;
            r_pos   <= '0;
            r_ovf   <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= S_MARK;
          end
        end

        S_MARK: begin
          if (r_pos == POS_FULL) begin
            // No room left for the terminating 1: abort and keep what was written.
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_data <= r_data | (BIT0 << r_pos);
            r_pos  <= r_pos + POS_W'(1);
            if (r_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT_GAP;
            end
          end
        end

        S_WAIT_GAP: begin
          if (gap_valid) begin
            r_cnt   <= gap_in;
            r_last  <= gap_last;
            r_state <= (gap_in == '0) ? S_MARK : S_ZEROS;
          end
        end

        S_ZEROS: begin
          // Zeros need no write because Data was cleared at start; only advance pos.
          if (r_pos == POS_FULL) begin
            r_ovf   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pos <= r_pos + POS_W'(1);
            r_cnt <= r_cnt - GAP_WIDTH'(1);
            if (r_cnt == GAP_WIDTH'(1)) r_state <= S_MARK;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
